// File: rtl/cordic_pkg.sv
// Shared constants, state encoding and arctangent table for the iterative CORDIC controller.
// Optional vectoring mode is enabled by defining CORDIC_VECTORING_EN.
package cordic_pkg;

    localparam int W       = 16;
    localparam int XY_FRAC = 14;
    localparam int Z_FRAC  = 13;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        DONE
    } state_t;

    // atan(2^-i) in Q2.13 radians, round-to-nearest
    localparam logic signed [W-1:0] ATAN_TAB [16] = '{
        16'sd6434, 16'sd3798, 16'sd2007, 16'sd1019,
        16'sd511,  16'sd256,  16'sd128,  16'sd64,
        16'sd32,   16'sd16,   16'sd8,    16'sd4,
        16'sd2,    16'sd1,    16'sd0,    16'sd0
    };

endpackage

// File: rtl/arith_rsh.sv
// 16-bit arithmetic right shifter: o = p >>> i, floor-rounded toward minus infinity.
module arith_rsh (
    input  logic signed [15:0] p,
    input  logic        [3:0]  i,
    output logic signed [15:0] o
);

    assign o = p >>> i;

endmodule

// File: rtl/cordic_atan_rom.sv
// Combinational lookup of atan(2^-idx) in Q2.13 for the CORDIC angle path.
module cordic_atan_rom
    import cordic_pkg::*;
(
    input  logic        [3:0]   i_idx,
    output logic signed [W-1:0] o_atan
);

    assign o_atan = ATAN_TAB[i_idx];

endmodule

// File: rtl/cordic_iter_ctrl.sv
// Iterative CORDIC controller: one micro-rotation per clock with valid/ready on both sides.
// Define CORDIC_VECTORING_EN to add the mode_vec input and vectoring mode.
module cordic_iter_ctrl
    import cordic_pkg::*;
#(
    parameter int N_ITER = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] x_in,
    input  logic signed [W-1:0] y_in,
    input  logic signed [W-1:0] z_in,
`ifdef CORDIC_VECTORING_EN
    input  logic                mode_vec,
`endif
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] x_out,
    output logic signed [W-1:0] y_out,
    output logic signed [W-1:0] z_out,
    output logic                busy
);

    state_t              r_state;
    state_t              w_nextState;
    logic        [3:0]   r_cnt;
    logic signed [W-1:0] r_x;
    logic signed [W-1:0] r_y;
    logic signed [W-1:0] r_z;
    logic signed [W-1:0] w_xShift;
    logic signed [W-1:0] w_yShift;
    logic signed [W-1:0] w_atan;
    logic signed [W-1:0] w_xNext;
    logic signed [W-1:0] w_yNext;
    logic signed [W-1:0] w_zNext;
    logic                w_dPos;
    logic                w_lastIter;

    arith_rsh u_xShift (.p(r_x), .i(r_cnt), .o(w_xShift));
    arith_rsh u_yShift (.p(r_y), .i(r_cnt), .o(w_yShift));

    cordic_atan_rom u_atan (.i_idx(r_cnt), .o_atan(w_atan));

`ifdef CORDIC_VECTORING_EN
    logic r_vec;
    // Vectoring steers y toward zero; rotation steers z toward zero.
    assign w_dPos = r_vec ? r_y[W-1] : ~r_z[W-1];
`else
    assign w_dPos = ~r_z[W-1];
`endif

    assign w_xNext    = w_dPos ? (r_x - w_yShift) : (r_x + w_yShift);
    assign w_yNext    = w_dPos ? (r_y + w_xShift) : (r_y - w_xShift);
    assign w_zNext    = w_dPos ? (r_z - w_atan)   : (r_z + w_atan);
    assign w_lastIter = (r_cnt == 4'(N_ITER - 1));

    always_comb begin
        w_nextState = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_nextState = ITER;
            end
            ITER: begin
                busy = 1'b1;
                if (w_lastIter) w_nextState = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Working registers double as the result outputs, so they hold in IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
`ifdef CORDIC_VECTORING_EN
            r_vec   <= 1'b0;
`endif
        end else begin
            r_state <= w_nextState;
            if (r_state == IDLE && in_valid) begin
                r_cnt <= 4'd0;
                r_x   <= x_in;
                r_y   <= y_in;
                r_z   <= z_in;
`ifdef CORDIC_VECTORING_EN
                r_vec <= mode_vec;
`endif
            end else if (r_state == ITER) begin
                r_cnt <= r_cnt + 4'd1;
                r_x   <= w_xNext;
                r_y   <= w_yNext;
                r_z   <= w_zNext;
            end
        end
    end

    assign x_out = r_x;
    assign y_out = r_y;
    assign z_out = r_z;

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// Directed, table-driven testbench for cordic_iter_ctrl and its arith_rsh shifter.
module tb_cordic_iter_ctrl;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] x_in;
    logic signed [15:0] y_in;
    logic signed [15:0] z_in;
`ifdef CORDIC_VECTORING_EN
    logic               mode_vec;
`endif
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] x_out;
    logic signed [15:0] y_out;
    logic signed [15:0] z_out;
    logic               busy;

    logic signed [15:0] shP;
    logic        [3:0]  shI;
    logic signed [15:0] shO;

    int nChecks = 0;
    int nFails  = 0;

    typedef struct {
        string name;
        int    x;
        int    y;
        int    z;
        int    vec;
        int    ex;
        int    ey;
        int    ez;
        int    tolXY;
        int    tolZ;
    } vec_t;

    typedef struct {
        int p;
        int i;
        int o;
    } shVec_t;

    always #5 clk = ~clk;

    cordic_iter_ctrl #(.N_ITER(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .x_in     (x_in),
        .y_in     (y_in),
        .z_in     (z_in),
`ifdef CORDIC_VECTORING_EN
        .mode_vec (mode_vec),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .x_out    (x_out),
        .y_out    (y_out),
        .z_out    (z_out),
        .busy     (busy)
    );

    arith_rsh u_shf (.p(shP), .i(shI), .o(shO));

    function automatic vec_t makeVec(input string n, input int x, input int y, input int z,
                                     input int vec, input int ex, input int ey, input int ez,
                                     input int tolXY, input int tolZ);
        vec_t v;
        v.name = n; v.x = x; v.y = y; v.z = z; v.vec = vec;
        v.ex = ex; v.ey = ey; v.ez = ez; v.tolXY = tolXY; v.tolZ = tolZ;
        return v;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected, input int tol);
        int diff;
        nChecks++;
        diff = actual - expected;
        if (diff < 0) diff = -diff;
        if (diff > tol) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (tol %0d)", name, actual, expected, tol);
        end
    endtask

    // Accept one operand set, scramble the inputs, then count edges until out_valid.
    task automatic applyStimulus(input int x, input int y, input int z, input int vec, output int lat);
        x_in     = 16'(x);
        y_in     = 16'(y);
        z_in     = 16'(z);
`ifdef CORDIC_VECTORING_EN
        mode_vec = vec[0];
`endif
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        x_in     = 16'sh1234;
        y_in     = -16'sd4321;
        z_in     = 16'sh0777;
`ifdef CORDIC_VECTORING_EN
        mode_vec = ~vec[0];
`endif
        lat = 0;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    task automatic releaseResult;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t   vecs[$];
        shVec_t shVecs[$];
        int     lat;
        int     heldX, heldY, heldZ;
        int     sawValid;

        vecs.push_back(makeVec("zeroIn",   0,    0, 0,     0, 0,     0,      0, 0, 0));
        vecs.push_back(makeVec("zeroAng",  9949, 0, 0,     0, 16384, 0,      0, 8, 2));
        vecs.push_back(makeVec("posPi4",   9949, 0, 6434,  0, 11585, 11585,  0, 8, 2));
        vecs.push_back(makeVec("negPi4",   9949, 0, -6434, 0, 11585, -11585, 0, 8, 2));
`ifdef CORDIC_VECTORING_EN
        vecs.push_back(makeVec("vector",   8192, 8192, 0,  1, 19079, 0,   6434, 10, 4));
`endif

        shVecs.push_back('{p: -1,     i: 3,  o: -1});
        shVecs.push_back('{p: -16,    i: 2,  o: -4});
        shVecs.push_back('{p: -17,    i: 2,  o: -5});
        shVecs.push_back('{p: 100,    i: 3,  o: 12});
        shVecs.push_back('{p: 32767,  i: 15, o: 0});
        shVecs.push_back('{p: -32768, i: 15, o: -1});
        shVecs.push_back('{p: 9949,   i: 0,  o: 9949});

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x_in      = '0;
        y_in      = '0;
        z_in      = '0;
`ifdef CORDIC_VECTORING_EN
        mode_vec  = 1'b0;
`endif
        shP       = '0;
        shI       = '0;
        tick();
        tick();

        checkOutput("rst_in_ready",  int'(in_ready),  1, 0);
        checkOutput("rst_out_valid", int'(out_valid), 0, 0);
        checkOutput("rst_busy",      int'(busy),      0, 0);
        checkOutput("rst_x",         int'(x_out),     0, 0);
        checkOutput("rst_y",         int'(y_out),     0, 0);
        checkOutput("rst_z",         int'(z_out),     0, 0);
        rst_n = 1'b1;
        tick();

        foreach (vecs[k]) begin
            applyStimulus(vecs[k].x, vecs[k].y, vecs[k].z, vecs[k].vec, lat);
            checkOutput({vecs[k].name, "_latency"}, lat, 16, 0);
            checkOutput({vecs[k].name, "_x"}, int'(x_out), vecs[k].ex, vecs[k].tolXY);
            checkOutput({vecs[k].name, "_y"}, int'(y_out), vecs[k].ey, vecs[k].tolXY);
            checkOutput({vecs[k].name, "_z"}, int'(z_out), vecs[k].ez, vecs[k].tolZ);
            releaseResult();
            checkOutput({vecs[k].name, "_idle_in_ready"}, int'(in_ready), 1, 0);
        end

        // Backpressure in DONE with an ignored in_valid pulse.
        applyStimulus(9949, 0, 6434, 0, lat);
        checkOutput("bp_latency", lat, 16, 0);
        heldX = int'(x_out);
        heldY = int'(y_out);
        heldZ = int'(z_out);
        for (int c = 0; c < 5; c++) begin
            in_valid = (c == 2);
            x_in     = 16'sd100;
            y_in     = 16'sd200;
            z_in     = 16'sd300;
            tick();
            checkOutput("bp_out_valid", int'(out_valid), 1, 0);
            checkOutput("bp_in_ready",  int'(in_ready),  0, 0);
            checkOutput("bp_x_hold",    int'(x_out),     heldX, 0);
            checkOutput("bp_y_hold",    int'(y_out),     heldY, 0);
            checkOutput("bp_z_hold",    int'(z_out),     heldZ, 0);
        end
        in_valid = 1'b0;
        releaseResult();
        checkOutput("bp_rel_in_ready",  int'(in_ready),  1, 0);
        checkOutput("bp_rel_out_valid", int'(out_valid), 0, 0);
        checkOutput("bp_rel_busy",      int'(busy),      0, 0);
        checkOutput("idle_x_hold",      int'(x_out),     heldX, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("idle_ready_noeffect", int'(in_ready), 1, 0);
        checkOutput("idle_y_hold",         int'(y_out),    heldY, 0);

        // Reset asserted at iteration 7 aborts with no result pulse.
        x_in     = 16'sd9949;
        y_in     = 16'sd0;
        z_in     = 16'sd6434;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (7) tick();
        checkOutput("mid_busy",      int'(busy),      1, 0);
        checkOutput("mid_out_valid", int'(out_valid), 0, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checkOutput("abort_in_ready",  int'(in_ready),  1, 0);
        checkOutput("abort_busy",      int'(busy),      0, 0);
        checkOutput("abort_out_valid", int'(out_valid), 0, 0);
        checkOutput("abort_x",         int'(x_out),     0, 0);
        checkOutput("abort_y",         int'(y_out),     0, 0);
        checkOutput("abort_z",         int'(z_out),     0, 0);
        sawValid = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (out_valid) sawValid++;
        end
        checkOutput("abort_no_pulse", sawValid, 0, 0);

        applyStimulus(9949, 0, 0, 0, lat);
        checkOutput("post_rst_latency", lat, 16, 0);
        checkOutput("post_rst_x", int'(x_out), 16384, 8);
        checkOutput("post_rst_y", int'(y_out), 0, 8);
        checkOutput("post_rst_z", int'(z_out), 0, 2);
        releaseResult();

        foreach (shVecs[k]) begin
            shP = 16'(shVecs[k].p);
            shI = 4'(shVecs[k].i);
            #1;
            checkOutput($sformatf("shift_%0d_by_%0d", shVecs[k].p, shVecs[k].i),
                        int'(shO), shVecs[k].o, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
